// File: rtl/alu_operand_stage_pkg.sv
// ============================================================================
// Module   : alu_operand_stage_pkg
// Brief    : Operand select encodings and constants shared by the operand stage
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_operand_stage_pkg;

    typedef enum logic [1:0] {
        A_RD1   = 2'd0,
        A_SEXT1 = 2'd1,
        A_1R    = 2'd2,
        A_ZERO  = 2'd3
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RD2  = 2'd0,
        B_EXT  = 2'd1,
        B_4    = 2'd2,
        B_ZERO = 2'd3
    } b_sel_e;

    localparam int unsigned C_FOUR = 4;

endpackage

`default_nettype wire

// File: rtl/alu_operand_stage_fwd_select.sv
// ============================================================================
// Module   : fwd_select
// Brief    : Fixed-priority EX > MEM > WB > RF forward mux for one source reg
// Revision : 1.0
// ============================================================================
`default_nettype none

module fwd_select #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] rr_i,
    input  logic [DATA_W-1:0]  rf_data_i,
    input  logic               ex_we_i,
    input  logic               ex_is_load_i,
    input  logic [RADDR_W-1:0] ex_wr_i,
    input  logic [DATA_W-1:0]  ex_wd_i,
    input  logic               mem_we_i,
    input  logic [RADDR_W-1:0] mem_wr_i,
    input  logic [DATA_W-1:0]  mem_wd_i,
    input  logic               wb_we_i,
    input  logic [RADDR_W-1:0] wb_wr_i,
    input  logic [DATA_W-1:0]  wb_wd_i,
    output logic [DATA_W-1:0]  fwd_o,
    output logic               ex_load_hit_o
);

    // A load in EX has no data yet, so it is skipped here and flagged instead
    always_comb begin
        fwd_o = rf_data_i;
        if (rr_i == '0) begin
            fwd_o = '0;
        end else if (ex_we_i && !ex_is_load_i && (ex_wr_i == rr_i)) begin
            fwd_o = ex_wd_i;
        end else if (mem_we_i && (mem_wr_i == rr_i)) begin
            fwd_o = mem_wd_i;
        end else if (wb_we_i && (wb_wr_i == rr_i)) begin
            fwd_o = wb_wd_i;
        end
    end

    assign ex_load_hit_o = ex_we_i && ex_is_load_i && (ex_wr_i == rr_i) && (rr_i != '0);

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module   : alu_operand_stage
// Brief    : ID/EX operand resolve, forwarding, load-use bubble and EX registers
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 20,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic               id_valid,
    input  logic [1:0]         A_sel,
    input  logic [1:0]         B_sel,
    input  logic [RADDR_W-1:0] id_rR1,
    input  logic [RADDR_W-1:0] id_rR2,
    input  logic [DATA_W-1:0]  RF_rD1,
    input  logic [DATA_W-1:0]  RF_rD2,
    input  logic [DATA_W-1:0]  SEXT_ext1,
    input  logic [IMM_W-1:0]   inst_imm,
    input  logic               ex_we,
    input  logic               ex_is_load,
    input  logic [RADDR_W-1:0] ex_wR,
    input  logic [DATA_W-1:0]  ex_wD,
    input  logic               mem_we,
    input  logic [RADDR_W-1:0] mem_wR,
    input  logic [DATA_W-1:0]  mem_wD,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_wR,
    input  logic [DATA_W-1:0]  wb_wD,
    input  logic               hold_in,
    input  logic               flush,
    output logic               id_stall,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ALU_A,
    output logic [DATA_W-1:0]  ALU_B,
    output logic [DATA_W-1:0]  ex_st_data,
    output logic [CNT_W-1:0]   hazard_cnt
);

    logic [DATA_W-1:0] fwd1, fwd2, a_mux, b_mux;
    logic              hit1, hit2, use1, use2, load_use;
    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, st_q, st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    fwd_select #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd1 (
        .rr_i(id_rR1), .rf_data_i(RF_rD1),
        .ex_we_i(ex_we), .ex_is_load_i(ex_is_load), .ex_wr_i(ex_wR), .ex_wd_i(ex_wD),
        .mem_we_i(mem_we), .mem_wr_i(mem_wR), .mem_wd_i(mem_wD),
        .wb_we_i(wb_we), .wb_wr_i(wb_wR), .wb_wd_i(wb_wD),
        .fwd_o(fwd1), .ex_load_hit_o(hit1)
    );

    fwd_select #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd2 (
        .rr_i(id_rR2), .rf_data_i(RF_rD2),
        .ex_we_i(ex_we), .ex_is_load_i(ex_is_load), .ex_wr_i(ex_wR), .ex_wd_i(ex_wD),
        .mem_we_i(mem_we), .mem_wr_i(mem_wR), .mem_wd_i(mem_wD),
        .wb_we_i(wb_we), .wb_wr_i(wb_wR), .wb_wd_i(wb_wD),
        .fwd_o(fwd2), .ex_load_hit_o(hit2)
    );

    always_comb begin
        a_mux = '0;
        case (a_sel_e'(A_sel))
            A_RD1:   a_mux = fwd1;
            A_SEXT1: a_mux = SEXT_ext1;
            A_1R:    a_mux = DATA_W'(inst_imm);
            default: a_mux = '0;
        endcase
    end

    always_comb begin
        b_mux = '0;
        case (b_sel_e'(B_sel))
            B_RD2:   b_mux = fwd2;
            B_EXT:   b_mux = SEXT_ext1;
            B_4:     b_mux = DATA_W'(C_FOUR);
            default: b_mux = '0;
        endcase
    end

    // B_EXT may be a store, whose data comes from rR2
    assign use1     = (a_sel_e'(A_sel) == A_RD1);
    assign use2     = (b_sel_e'(B_sel) == B_RD2) || (b_sel_e'(B_sel) == B_EXT);
    assign load_use = id_valid && ex_valid_q && ((use1 && hit1) || (use2 && hit2));
    assign id_stall = hold_in || (load_use && !flush);

    always_comb begin
        ex_valid_d = ex_valid_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        st_d       = st_q;
        cnt_d      = cnt_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            alu_a_d    = '0;
            alu_b_d    = '0;
            st_d       = '0;
        end else if (!hold_in) begin
            if (load_use) begin
                ex_valid_d = 1'b0;
                alu_a_d    = '0;
                alu_b_d    = '0;
                st_d       = '0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                ex_valid_d = id_valid;
                alu_a_d    = a_mux;
                alu_b_d    = b_mux;
                st_d       = fwd2;
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            ex_valid_q <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            st_q       <= '0;
            cnt_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            st_q       <= st_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ALU_A      = alu_a_q;
    assign ALU_B      = alu_b_q;
    assign ex_st_data = st_q;
    assign hazard_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
// Module   : tb_alu_operand_stage
// Brief    : Self-checking bench for alu_operand_stage (vector table + sequences)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    localparam int CNT_W = 2;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        id_valid;
    logic [1:0]  A_sel, B_sel;
    logic [4:0]  id_rR1, id_rR2, ex_wR, mem_wR, wb_wR;
    logic [31:0] RF_rD1, RF_rD2, SEXT_ext1, ex_wD, mem_wD, wb_wD;
    logic [19:0] inst_imm;
    logic        ex_we, ex_is_load, mem_we, wb_we, hold_in, flush;
    logic        id_stall, ex_valid;
    logic [31:0] ALU_A, ALU_B, ex_st_data;
    logic [CNT_W-1:0] hazard_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        idv;
        logic [1:0]  a_sel, b_sel;
        logic [4:0]  rr1, rr2, exr, mr, wr;
        logic [31:0] rd1, rd2, sext, exd, md, wd;
        logic [19:0] imm;
        logic        exw, exl, mw, ww;
        logic [31:0] ea, eb, es;
        logic        ev;
    } vec_t;

    typedef struct {
        logic [31:0] a, b, st;
        logic        v;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    alu_operand_stage #(.DATA_W(32), .IMM_W(20), .RADDR_W(5), .CNT_W(CNT_W)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid),
        .A_sel(A_sel), .B_sel(B_sel), .id_rR1(id_rR1), .id_rR2(id_rR2),
        .RF_rD1(RF_rD1), .RF_rD2(RF_rD2), .SEXT_ext1(SEXT_ext1), .inst_imm(inst_imm),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wR(ex_wR), .ex_wD(ex_wD),
        .mem_we(mem_we), .mem_wR(mem_wR), .mem_wD(mem_wD),
        .wb_we(wb_we), .wb_wR(wb_wR), .wb_wD(wb_wD),
        .hold_in(hold_in), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ex_st_data(ex_st_data), .hazard_cnt(hazard_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; A_sel = 0; B_sel = 0; id_rR1 = 0; id_rR2 = 0;
        RF_rD1 = 0; RF_rD2 = 0; SEXT_ext1 = 0; inst_imm = 0;
        ex_we = 0; ex_is_load = 0; ex_wR = 0; ex_wD = 0;
        mem_we = 0; mem_wR = 0; mem_wD = 0; wb_we = 0; wb_wR = 0; wb_wD = 0;
        hold_in = 0; flush = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        idle();
        id_valid = v.idv; A_sel = v.a_sel; B_sel = v.b_sel; id_rR1 = v.rr1; id_rR2 = v.rr2;
        RF_rD1 = v.rd1; RF_rD2 = v.rd2; SEXT_ext1 = v.sext; inst_imm = v.imm;
        ex_we = v.exw; ex_is_load = v.exl; ex_wR = v.exr; ex_wD = v.exd;
        mem_we = v.mw; mem_wR = v.mr; mem_wD = v.md; wb_we = v.ww; wb_wR = v.wr; wb_wD = v.wd;
    endtask

    task automatic setup_valid(input logic [19:0] imm);
        idle();
        id_valid = 1; A_sel = A_1R; B_sel = B_4; inst_imm = imm;
        tick();
    endtask

    // EX holds a load to r7 and the ID instruction reads r7 through operand A
    task automatic drive_lu();
        idle();
        id_valid = 1; A_sel = A_RD1; id_rR1 = 7; B_sel = B_4; RF_rD1 = 32'h0BAD0BAD;
        ex_we = 1; ex_is_load = 1; ex_wR = 7; ex_wD = 32'hDEADBEEF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        exp_t e;

        // Reset with busy inputs
        drive_lu();
        A_sel = A_1R; inst_imm = 20'hFFFFF; B_sel = B_RD2; id_rR2 = 3; RF_rD2 = 32'h77;
        cpu_rst = 1;
        tick();
        hold_in = 1;
        #1 chk("rst_stall_eq_hold1", {31'd0, id_stall}, 32'd1);
        tick();
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ALU_A", ALU_A, 32'd0);
        chk("rst_ALU_B", ALU_B, 32'd0);
        chk("rst_st_data", ex_st_data, 32'd0);
        chk("rst_hazard_cnt", 32'(hazard_cnt), 32'd0);
        hold_in = 0;
        #1 chk("rst_stall_eq_hold0", {31'd0, id_stall}, 32'd0);
        cpu_rst = 0;

        // Vector table: no EX load hits a used source in any of these
        v = '{default: '0}; v.idv = 1; v.a_sel = A_1R; v.imm = 20'hABCDE; v.b_sel = B_4;
        v.ea = 32'h000ABCDE; v.eb = 32'd4; v.es = 0; v.ev = 1; vecs.push_back(v);
        v = '{default: '0}; v.idv = 1; v.a_sel = A_RD1; v.b_sel = B_RD2; v.rr1 = 5; v.rr2 = 5;
        v.rd1 = 32'hEE; v.rd2 = 32'hEE; v.exw = 1; v.exr = 5; v.exd = 32'h11;
        v.mw = 1; v.mr = 5; v.md = 32'h22; v.ww = 1; v.wr = 5; v.wd = 32'h33;
        v.ea = 32'h11; v.eb = 32'h11; v.es = 32'h11; v.ev = 1; vecs.push_back(v);
        v.exw = 0; v.ea = 32'h22; v.eb = 32'h22; v.es = 32'h22; vecs.push_back(v);
        v.mw = 0; v.ea = 32'h33; v.eb = 32'h33; v.es = 32'h33; vecs.push_back(v);
        v.ww = 0; v.rd1 = 32'hAAAA0001; v.rr2 = 6; v.rd2 = 32'hBBBB0002;
        v.ea = 32'hAAAA0001; v.eb = 32'hBBBB0002; v.es = 32'hBBBB0002; vecs.push_back(v);
        v = '{default: '0}; v.idv = 1; v.a_sel = A_RD1; v.b_sel = 2'd3; v.rr1 = 0; v.rd1 = 32'h1234;
        v.exw = 1; v.exr = 0; v.exd = 32'hFF; v.ea = 0; v.eb = 0; v.es = 0; v.ev = 1; vecs.push_back(v);
        v = '{default: '0}; v.idv = 1; v.a_sel = A_SEXT1; v.b_sel = B_EXT; v.sext = 32'hFFFFFF80;
        v.rr2 = 9; v.rd2 = 32'h1; v.mw = 1; v.mr = 9; v.md = 32'h99;
        v.ea = 32'hFFFFFF80; v.eb = 32'hFFFFFF80; v.es = 32'h99; v.ev = 1; vecs.push_back(v);
        v = '{default: '0}; v.idv = 1; v.a_sel = 2'd3; v.b_sel = B_RD2; v.rr2 = 3; v.rd2 = 32'h1;
        v.ww = 1; v.wr = 3; v.wd = 32'h5A; v.mw = 1; v.mr = 4; v.md = 32'h44;
        v.ea = 0; v.eb = 32'h5A; v.es = 32'h5A; v.ev = 1; vecs.push_back(v);
        v = '{default: '0}; v.idv = 1; v.a_sel = A_1R; v.imm = 20'd1; v.rr1 = 11; v.b_sel = B_4;
        v.rr2 = 12; v.rd2 = 32'h12; v.exw = 1; v.exl = 1; v.exr = 11; v.exd = 32'hDEAD;
        v.ea = 32'd1; v.eb = 32'd4; v.es = 32'h12; v.ev = 1; vecs.push_back(v);
        v = '{default: '0}; v.idv = 0; v.a_sel = A_1R; v.imm = 20'h7; v.b_sel = B_4;
        v.ea = 32'd7; v.eb = 32'd4; v.es = 0; v.ev = 0; vecs.push_back(v);

        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            exp_q.push_back('{a: vecs[i].ea, b: vecs[i].eb, st: vecs[i].es, v: vecs[i].ev});
            #1 chk($sformatf("vec%0d_stall", i), {31'd0, id_stall}, 32'd0);
            tick();
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_ALU_A", i), ALU_A, e.a);
            chk($sformatf("vec%0d_ALU_B", i), ALU_B, e.b);
            chk($sformatf("vec%0d_st", i), ex_st_data, e.st);
            chk($sformatf("vec%0d_valid", i), {31'd0, ex_valid}, {31'd0, e.v});
        end

        // Load-use: one bubble, then MEM supplies the load data
        setup_valid(20'd1);
        drive_lu();
        #1 chk("lu_stall", {31'd0, id_stall}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_A", ALU_A, 32'd0);
        chk("lu_cnt", 32'(hazard_cnt), 32'd1);
        idle();
        id_valid = 1; A_sel = A_RD1; id_rR1 = 7; B_sel = B_4;
        mem_we = 1; mem_wR = 7; mem_wD = 32'h1234;
        #1 chk("lu_recover_stall", {31'd0, id_stall}, 32'd0);
        tick();
        chk("lu_recover_A", ALU_A, 32'h1234);
        chk("lu_recover_valid", {31'd0, ex_valid}, 32'd1);

        // Flush beats load-use
        drive_lu();
        flush = 1;
        #1 chk("flush_lu_stall", {31'd0, id_stall}, 32'd0);
        tick();
        chk("flush_lu_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_lu_A", ALU_A, 32'd0);
        chk("flush_lu_cnt", 32'(hazard_cnt), 32'd1);

        // Hold beats load-use, then the hazard is seen again once hold drops
        setup_valid(20'h55);
        drive_lu();
        hold_in = 1;
        #1 chk("hold_lu_stall", {31'd0, id_stall}, 32'd1);
        tick();
        chk("hold_lu_A", ALU_A, 32'h55);
        chk("hold_lu_B", ALU_B, 32'd4);
        chk("hold_lu_valid", {31'd0, ex_valid}, 32'd1);
        chk("hold_lu_cnt", 32'(hazard_cnt), 32'd1);
        hold_in = 0;
        #1 chk("unhold_lu_stall", {31'd0, id_stall}, 32'd1);
        tick();
        chk("unhold_lu_valid", {31'd0, ex_valid}, 32'd0);
        chk("unhold_lu_cnt", 32'(hazard_cnt), 32'd2);

        // Reset while a load-use stall is pending
        setup_valid(20'd3);
        drive_lu();
        cpu_rst = 1;
        tick();
        cpu_rst = 0;
        chk("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_mid_A", ALU_A, 32'd0);
        chk("rst_mid_cnt", 32'(hazard_cnt), 32'd0);

        // Counter saturation over five bubbles
        for (int k = 0; k < 5; k++) begin
            setup_valid(20'd9);
            drive_lu();
            tick();
            chk($sformatf("sat%0d_valid", k), {31'd0, ex_valid}, 32'd0);
            chk($sformatf("sat%0d_cnt", k), 32'(hazard_cnt), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
